drap_ifetch: RTL and testbench
==============================

# drap_ifetch

Instruction fetch unit for the DRAP MIPS datapath: the read-side initiator for the DRAP instruction memory. It owns the program counter and drives word addresses into the memory. It captures the returned instruction words and hands them to the decode stage over a valid/ready handshake. It supports pipeline stalls, decode backpressure and branch/jump redirects without losing, duplicating or reordering instructions.

## Interface
- ADDR_W, 7, instruction memory word-address width (128 words)
- DATA_W, 32, instruction width
- RESET_PC, 32'h0000_0000, byte address fetched first after reset

Ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_address  out  ADDR_W  word address to instruction memory, equal to pc_q[ADDR_W+1:2]
- imem_write  out  1  memory write enable, tied 0
- imem_data_in  out  DATA_W  memory write data, tied 0
- imem_data_out  in  DATA_W  memory read data, valid the cycle after the address edge
- stall  in  1  hazard stall; blocks new issue only
- redirect_valid  in  1  single-cycle branch/jump request
- redirect_pc  in  32  redirect byte address; bits [1:0] are ignored
- id_valid  out  1  id_instr/id_pc hold a valid instruction
- id_ready  in  1  decode accepts the word at this edge
- id_instr  out  DATA_W  fetched instruction
- id_pc  out  32  byte address of id_instr
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32

## Operation
- Memory model: synchronous read. Address sampled at edge k gives data on imem_data_out during the cycle after edge k.
- State registers:
  - pc_q: address presented this cycle
  - inflight_valid / inflight_pc: a word arrives on imem_data_out this cycle
  - skid_valid / skid_instr / skid_pc: one-entry skid buffer
  - output registers id_*
- accept = !id_valid || id_ready.
- issue = !stall && !skid_valid && (accept || !inflight_valid).
  - On issue: pc_q <= pc_q + 4, inflight_valid <= 1, inflight_pc <= pc_q.
  - Otherwise pc_q holds and inflight_valid <= 0.
- Output load, when accept:
  - skid_valid: id_* <= skid, skid_valid <= 0.
  - Else inflight_valid: id_* <= {imem_data_out, inflight_pc}.
  - Else id_valid <= 0.
- Skid fill: when inflight_valid and the word is not loaded into id_* (because !accept), skid <= {imem_data_out, inflight_pc} and skid_valid <= 1.
- Invariant: skid_valid and inflight_valid are never both 1. The bench asserts this.
- Redirect has priority over everything, including stall and id_ready. At that edge:
  - pc_q <= {redirect_pc[31:2], 2'b00}
  - inflight_valid, skid_valid and id_valid all <= 0 (flush)
- Wrap-around:
  - pc_q is 32-bit and wraps at 2^32.
  - imem_address wraps 127 -> 0 by truncation.
  - id_pc keeps the full 32-bit value (e.g. 0x200 fetches word 0).
- Reset, asynchronous, also mid-operation:
  - pc_q = RESET_PC, so imem_address = RESET_PC[ADDR_W+1:2]
  - id_valid = 0, id_instr = 0, id_pc = 0, id_pc_plus4 = 4
  - inflight_valid = 0, skid_valid = 0
- The block never writes memory. imem_write and imem_data_in are constant 0, including during reset.

## Timing
- Throughput: 1 instruction per cycle while id_ready=1 and stall=0.
- Reset latency: the first issue happens at the first edge after reset_n deasserts. id_valid rises after the second edge, with id_pc=RESET_PC.
- Redirect latency: with redirect sampled at edge E0, the target issues at E1 and id_valid=1 after E2 with id_pc=target. No stale word is ever presented after E0.
- Backpressure: id_instr, id_pc and id_valid stay stable while id_valid=1 and id_ready=0.
  - Exactly one word may land in the skid.
  - Issue stops within one cycle.
- stall: pc_q holds. A word already in flight still completes into id_* or the skid. Output drains normally.
- stall and redirect in the same cycle: the redirect is taken, and the target waits in pc_q until stall drops.

## Test plan
- Stream: preload mem[0..3] = 0x11111111, 0x22222222, 0x33333333, 0x44444444; release reset with id_ready=1. id_valid rises 2 edges later; id_instr/id_pc = (0x11111111, 0), (0x22222222, 4), (0x33333333, 8), (0x44444444, 0xC) on consecutive cycles.
- Backpressure: hold id_ready=0 for 3 cycles while id_pc=4. Outputs hold (0x22222222, 4). After release, the sequence resumes at 8, 0xC with no gap larger than 1 cycle and no duplicate.
- Redirect with wrap: preload mem[126]=0xAAAAAAAA, mem[127]=0xBBBBBBBB, mem[0]=0x11111111. Pulse redirect_pc=0x1F8 while id_ready=0 and the skid is full. Output is flushed; the next words are (0xAAAAAAAA, 0x1F8), (0xBBBBBBBB, 0x1FC), (0x11111111, 0x200) with imem_address=0.
- Misaligned redirect: redirect_pc=0x103 -> next id_pc=0x100, imem_address=64.
- Redirect coincident with stall=1 for 4 cycles: imem_address=target throughout, id_valid=0. The first id_valid comes 2 edges after stall drops.
- Reset mid-stream: drive reset_n low between edges while id_valid=1. id_valid=0 and imem_address=0 immediately, without waiting for an edge. After release, the stream restarts at id_pc=0 and imem_write stays 0 throughout.

Source files
------------

// File: rtl/drap_ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : drap_ifetch
//  Purpose  : DRAP instruction fetch unit. Owns the PC and issues word reads
//             to a synchronous-read instruction memory. Returned words are
//             presented to decode over a valid/ready handshake, backed by a
//             one-entry skid buffer. Redirects flush every stage.
//  Revision : 1.0  initial release
// ============================================================================
module drap_ifetch #(
    parameter int          ADDR_W   = 7,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] imem_address,
    output logic              imem_write,
    output logic [DATA_W-1:0] imem_data_in,
    input  logic [DATA_W-1:0] imem_data_out,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc_plus4
);

    localparam logic [31:0] c_PC_STEP   = 32'd4;
    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0]       r_pc;
    logic              r_inflight_valid;
    logic [31:0]       r_inflight_pc;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_instr;
    logic [31:0]       r_skid_pc;
    logic              r_id_valid;
    logic [DATA_W-1:0] r_id_instr;
    logic [31:0]       r_id_pc;

    logic w_accept;
    logic w_issue;

    // Output stage can take a word when empty or being drained this edge.
    // A new read may only start if its data is guaranteed a landing place:
    // the skid is empty and either the output moves or nothing is in flight.
    assign w_accept = !r_id_valid || id_ready;
    assign w_issue  = !stall && !r_skid_valid && (w_accept || !r_inflight_valid);

    // Address truncation gives the natural 127 -> 0 wrap of the word index.
    assign imem_address = r_pc[ADDR_W+1:2];
    assign imem_write   = 1'b0;
    assign imem_data_in = '0;

    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc + c_PC_STEP;

    // PC and in-flight tracking: redirect wins, otherwise advance on issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc             <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= '0;
        end else if (redirect_valid) begin
            r_pc             <= redirect_pc & c_WORD_MASK;
            r_inflight_valid <= 1'b0;
        end else if (w_issue) begin
            r_pc             <= r_pc + c_PC_STEP;
            r_inflight_valid <= 1'b1;
            r_inflight_pc    <= r_pc;
        end else begin
            r_inflight_valid <= 1'b0;
        end
    end

    // Skid buffer: catches the arriving word when the output stage is blocked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (redirect_valid) begin
            r_skid_valid <= 1'b0;
        end else if (w_accept) begin
            r_skid_valid <= 1'b0;
        end else if (r_inflight_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_instr <= imem_data_out;
            r_skid_pc    <= r_inflight_pc;
        end
    end

    // Output stage: skid has priority over the in-flight word to keep order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
            r_id_pc    <= '0;
        end else if (redirect_valid) begin
            r_id_valid <= 1'b0;
        end else if (w_accept) begin
            if (r_skid_valid) begin
                r_id_valid <= 1'b1;
                r_id_instr <= r_skid_instr;
                r_id_pc    <= r_skid_pc;
            end else if (r_inflight_valid) begin
                r_id_valid <= 1'b1;
                r_id_instr <= imem_data_out;
                r_id_pc    <= r_inflight_pc;
            end else begin
                r_id_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_drap_ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_drap_ifetch
//  Purpose  : Directed self-checking bench for drap_ifetch with a synchronous
//             read instruction memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_drap_ifetch;

    logic        clk;
    logic        reset_n;
    logic [6:0]  imem_address;
    logic        imem_write;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    logic [31:0] mem [128];

    int n_checks;
    int n_errors;

    drap_ifetch #(
        .ADDR_W   (7),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_address   (imem_address),
        .imem_write     (imem_write),
        .imem_data_in   (imem_data_in),
        .imem_data_out  (imem_data_out),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: address sampled at the edge, data next cycle.
    always @(posedge clk) imem_data_out <= mem[imem_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_id(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        check({tag, ".valid"}, 32'(id_valid), 32'd1);
        check({tag, ".instr"}, id_instr, instr);
        check({tag, ".pc"}, id_pc, pc);
        check({tag, ".pc4"}, id_pc_plus4, pc + 32'd4);
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".valid"}, 32'(id_valid), 32'd0);
    endtask

    // One clock: advance past the edge and sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("no_write", 32'(imem_write) | imem_data_in, 32'd0);
        check("skid_inflight_excl",
              32'(dut.r_skid_valid & dut.r_inflight_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'hD000_0000 | 32'(i);
        mem[0]   = 32'h1111_1111;
        mem[1]   = 32'h2222_2222;
        mem[2]   = 32'h3333_3333;
        mem[3]   = 32'h4444_4444;
        mem[8]   = 32'h8888_8888;
        mem[64]  = 32'h6464_6464;
        mem[126] = 32'hAAAA_AAAA;
        mem[127] = 32'hBBBB_BBBB;

        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(id_valid), 32'd0);
        check("rst.instr", id_instr, 32'd0);
        check("rst.pc", id_pc, 32'd0);
        check("rst.pc4", id_pc_plus4, 32'd4);
        check("rst.addr", 32'(imem_address), 32'd0);
        check("rst.write", 32'(imem_write) | imem_data_in, 32'd0);

        // Stream: valid two edges after release
        reset_n = 1'b1;
        step();                                   // E1: issue 0
        check_empty("s1");
        check("s1.addr", 32'(imem_address), 32'd1);
        step(); check_id("s2", 32'h1111_1111, 32'h0);   // E2
        step(); check_id("s3", 32'h2222_2222, 32'h4);   // E3

        // Backpressure for 3 cycles at id_pc=4
        id_ready = 1'b0;
        step(); check_id("bp1", 32'h2222_2222, 32'h4);  // E4: word 8 to skid
        step(); check_id("bp2", 32'h2222_2222, 32'h4);
        step(); check_id("bp3", 32'h2222_2222, 32'h4);
        id_ready = 1'b1;
        step(); check_id("bp4", 32'h3333_3333, 32'h8);  // E7: skid drains
        step(); check_empty("bp5");                      // E8: single bubble
        step(); check_id("bp6", 32'h4444_4444, 32'hC);  // E9

        // Fill skid, then redirect to 0x1F8
        id_ready = 1'b0;
        step(); check_id("rw0", 32'h4444_4444, 32'hC);  // E10
        check("rw0.skid", 32'(dut.r_skid_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_01F8;
        step();                                          // E11: flush
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        check_empty("rw1");
        check("rw1.addr", 32'(imem_address), 32'd126);
        step(); check_empty("rw2");                      // E12: issue 0x1F8
        step(); check_id("rw3", 32'hAAAA_AAAA, 32'h1F8); // E13
        check("rw3.addr", 32'(imem_address), 32'd0);
        step(); check_id("rw4", 32'hBBBB_BBBB, 32'h1FC);
        step(); check_id("rw5", 32'h1111_1111, 32'h200);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();                                          // E16
        redirect_valid = 1'b0;
        check_empty("ma1");
        check("ma1.addr", 32'(imem_address), 32'd64);
        step(); check_empty("ma2");
        step(); check_id("ma3", 32'h6464_6464, 32'h100);

        // Redirect coincident with a 4-cycle stall
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0020;
        stall          = 1'b1;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rs.addr", 32'(imem_address), 32'd8);
            check_empty("rs");
            if (i < 3) step();
        end
        stall = 1'b0;
        step(); check_empty("rs5");
        step(); check_id("rs6", 32'h8888_8888, 32'h20);
        step(); check_id("rs7", 32'hD000_0009, 32'h24);

        // Asynchronous reset mid-stream
        #2 reset_n = 1'b0;
        #1;
        check_empty("mr");
        check("mr.addr", 32'(imem_address), 32'd0);
        check("mr.pc", id_pc, 32'd0);
        check("mr.write", 32'(imem_write) | imem_data_in, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step(); check_empty("mr1");
        step(); check_id("mr2", 32'h1111_1111, 32'h0);
        step(); check_id("mr3", 32'h2222_2222, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
